// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU definitions: op encodings (mux input order) and issue FSM states.
// No logic, no latency.
// No flow control.
package alu_issue_ctrl_pkg;

  // Op codes map directly onto mux bank inputs i1..i8; no decode anywhere.
  localparam logic [2:0] OP_0 = 3'b000;
  localparam logic [2:0] OP_1 = 3'b001;
  localparam logic [2:0] OP_2 = 3'b010;
  localparam logic [2:0] OP_3 = 3'b011;
  localparam logic [2:0] OP_4 = 3'b100;
  localparam logic [2:0] OP_5 = 3'b101;
  localparam logic [2:0] OP_6 = 3'b110;
  localparam logic [2:0] OP_7 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of command, function-unit/mux and result signals around the issue stage.
// No logic, no latency.
// Command and result sides use valid/ready; the mux side is free-running.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       sel;
  logic [WIDTH-1:0] fu_a;
  logic [WIDTH-1:0] fu_b;
  logic [WIDTH-1:0] mux_o;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_neg;
  logic [CNT_W-1:0] op_count;

  // Issue stage side.
  modport slave (
    input  in_valid, in_op, in_a, in_b, mux_o, out_ready,
    output in_ready, sel, fu_a, fu_b, out_valid, out_result, out_zero, out_neg, op_count
  );

  // Environment side: command source, mux bank and result sink.
  modport master (
    output in_valid, in_op, in_a, in_b, mux_o, out_ready,
    input  in_ready, sel, fu_a, fu_b, out_valid, out_result, out_zero, out_neg, op_count
  );
endinterface

// File: rtl/alu_flag_gen.sv
// Zero / negative flags of a WIDTH-bit value.
// Purely combinational, zero latency.
// No flow control.
module alu_flag_gen #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_value,
  output logic             o_zero,
  output logic             o_neg
);

  assign o_zero = (i_value == '0);
  assign o_neg  = i_value[WIDTH-1];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage ahead of the ALU mux bank: registers op/operands, captures the muxed result with flags.
// Accept at edge t, result captured at edge t+1, out_valid after t+1; peak one command per 2 cycles.
// Result held stable until out_ready; a new command is taken only as the current result drains.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  alu_issue_ctrl_if.slave bus
);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_consume;
  logic             w_zero;
  logic             w_neg;

  logic [2:0]       r_sel;
  logic [WIDTH-1:0] r_fu_a;
  logic [WIDTH-1:0] r_fu_b;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_neg;
  logic [CNT_W-1:0] r_count;

  assign w_accept  = bus.in_valid && w_in_ready;
  assign w_consume = w_out_valid && bus.out_ready;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flags (
    .i_value (bus.mux_o),
    .o_zero  (w_zero),
    .o_neg   (w_neg)
  );

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state and handshake outputs; ready never looks at in_valid, valid never at out_ready.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready;
        if (bus.out_ready) w_next_state = bus.in_valid ? ST_EXEC : ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Select and operands move only on an accepting edge so the mux bank sees no spurious changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel  <= OP_0;
      r_fu_a <= '0;
      r_fu_b <= '0;
    end else if (w_accept) begin
      r_sel  <= bus.in_op;
      r_fu_a <= bus.in_a;
      r_fu_b <= bus.in_b;
    end
  end

  // Capture the settled mux output and its flags at the end of the settle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_result <= bus.mux_o;
      r_zero   <= w_zero;
      r_neg    <= w_neg;
    end
  end

  // Count results taken downstream; wraps without saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_count <= '0;
    else if (w_consume) r_count <= r_count + CNT_W'(1);
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.sel        = r_sel;
  assign bus.fu_a       = r_fu_a;
  assign bus.fu_b       = r_fu_b;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_result = r_result;
  assign bus.out_zero   = r_zero;
  assign bus.out_neg    = r_neg;
  assign bus.op_count   = r_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: driver pushes expected results, monitor pops and compares.
// Mux bank modelled as a plain function of (sel, fu_a, fu_b).
// out_ready driven always-high, random or held low depending on the phase.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;   // small so wrap-around happens during the random phase

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             neg;
    int               acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) ifc ();

  alu_issue_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  function automatic logic [WIDTH-1:0] mux_fn(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      OP_0:    return a + b;
      OP_1:    return a - b;
      OP_2:    return a & b;
      OP_3:    return a | b;
      OP_4:    return ~(a ^ b);
      OP_5:    return ~a;
      OP_6:    return a ^ b;
      OP_7:    return {a[WIDTH-2:0], 1'b0};
      default: return '0;
    endcase
  endfunction

  assign ifc.mux_o = mux_fn(ifc.sel, ifc.fu_a, ifc.fu_b);

  cmd_t cmd_q[$];
  exp_t sb_q[$];
  int   acc_cyc_q[$];
  int   cons_cyc_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: held low
  int gap_pct = 0;
  bit presenting = 0;
  bit acc_pending = 0;
  cmd_t acc_cmd;
  cmd_t drv_c;
  logic [WIDTH-1:0] drv_r;
  exp_t mon_e;
  bit   exp_valid;
  bit   exp_rdy;

  logic [2:0]       exp_sel = '0;
  logic [WIDTH-1:0] exp_fa = '0;
  logic [WIDTH-1:0] exp_fb = '0;
  int               exp_count = 0;

  logic [WIDTH-1:0] last_res = '0;
  logic             last_zero = 1'b0;
  logic             last_neg = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: commits last accept into the model, drives out_ready and the next command.
  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_op     = '0;
    ifc.in_a      = '0;
    ifc.in_b      = '0;
    ifc.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (acc_pending) begin
        exp_sel     = acc_cmd.op;
        exp_fa      = acc_cmd.a;
        exp_fb      = acc_cmd.b;
        acc_pending = 0;
      end
      if (!rst_n) begin
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        presenting    = 0;
        continue;
      end
      case (ready_mode)
        0:       ifc.out_ready = 1'b1;
        1:       ifc.out_ready = 1'($urandom_range(0, 1));
        default: ifc.out_ready = 1'b0;
      endcase
      if (!presenting && cmd_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) presenting = 1;
      ifc.in_valid = presenting;
      if (presenting) begin
        ifc.in_op = cmd_q[0].op;
        ifc.in_a  = cmd_q[0].a;
        ifc.in_b  = cmd_q[0].b;
      end
      #1;
      if (presenting && ifc.in_ready) begin
        drv_c = cmd_q.pop_front();
        drv_r = mux_fn(drv_c.op, drv_c.a, drv_c.b);
        sb_q.push_back('{res: drv_r, zero: (drv_r == '0), neg: drv_r[WIDTH-1], acc: cyc});
        acc_cyc_q.push_back(cyc);
        acc_cmd     = drv_c;
        acc_pending = 1;
        presenting  = 0;
      end
    end
  end

  // Monitor: compares handshake, registered mux drive, counter and result against the model.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) continue;
      exp_valid = (sb_q.size() > 0) && (cyc >= sb_q[0].acc + 2);
      exp_rdy   = !((sb_q.size() > 0) && (sb_q[$].acc == cyc - 1)) && (!exp_valid || ifc.out_ready);
      check("out_valid", ifc.out_valid, exp_valid);
      check("in_ready", ifc.in_ready, exp_rdy);
      check("sel", ifc.sel, exp_sel);
      check("fu_a", ifc.fu_a, exp_fa);
      check("fu_b", ifc.fu_b, exp_fb);
      check("op_count", ifc.op_count, exp_count);
      if (ifc.out_valid && sb_q.size() > 0) begin
        mon_e = sb_q[0];
        check("out_result", ifc.out_result, mon_e.res);
        check("out_zero", ifc.out_zero, mon_e.zero);
        check("out_neg", ifc.out_neg, mon_e.neg);
        if (ifc.out_ready) begin
          void'(sb_q.pop_front());
          exp_count = (exp_count + 1) % (1 << CNT_W);
          cons_cyc_q.push_back(cyc);
          last_res  = ifc.out_result;
          last_zero = ifc.out_zero;
          last_neg  = ifc.out_neg;
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((cmd_q.size() > 0 || sb_q.size() > 0 || presenting) && n < budget) begin
      @(negedge clk);
      n++;
    end
    #3;
    check("drain", cmd_q.size() + sb_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sel"}, ifc.sel, 0);
    check({tag, "_fu_a"}, ifc.fu_a, 0);
    check({tag, "_fu_b"}, ifc.fu_b, 0);
    check({tag, "_out_valid"}, ifc.out_valid, 0);
    check({tag, "_out_result"}, ifc.out_result, 0);
    check({tag, "_out_zero"}, ifc.out_zero, 0);
    check({tag, "_out_neg"}, ifc.out_neg, 0);
    check({tag, "_op_count"}, ifc.op_count, 0);
    check({tag, "_in_ready"}, ifc.in_ready, 1);
  endtask

  initial begin
    int n;
    int base;
    int base_count;
    cmd_t c;

    // Power-on reset.
    repeat (3) @(negedge clk);
    #3;
    check_reset_values("rst");
    rst_n = 1'b1;

    // Single add.
    ready_mode = 0;
    cmd_q.push_back('{op: OP_0, a: 8'h05, b: 8'h03});
    wait_idle(50);
    check("single_res", last_res, 8'h08);
    check("single_zero", last_zero, 0);
    check("single_neg", last_neg, 0);
    check("single_count", ifc.op_count, 1);

    // Flags via XOR.
    cmd_q.push_back('{op: OP_6, a: 8'hA5, b: 8'hA5});
    wait_idle(50);
    check("xor_zero_res", last_res, 8'h00);
    check("xor_zero_flag", last_zero, 1);
    cmd_q.push_back('{op: OP_6, a: 8'hFF, b: 8'h0F});
    wait_idle(50);
    check("xor_neg_res", last_res, 8'hF0);
    check("xor_neg_flag", last_neg, 1);
    check("xor_neg_zero", last_zero, 0);

    // Backpressure: result held while out_ready is low, next command waits.
    ready_mode = 2;
    cmd_q.push_back('{op: OP_1, a: 8'h20, b: 8'h05});
    n = 0;
    @(negedge clk);
    #3;
    while (!ifc.out_valid && n < 20) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("bp_valid", ifc.out_valid, 1);
    cmd_q.push_back('{op: OP_3, a: 8'h41, b: 8'h12});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #3;
      check("bp_in_ready", ifc.in_ready, 0);
      check("bp_out_valid", ifc.out_valid, 1);
      check("bp_result", ifc.out_result, 8'h1B);
      check("bp_sel", ifc.sel, OP_1);
      check("bp_fu_a", ifc.fu_a, 8'h20);
    end
    ready_mode = 0;
    wait_idle(50);
    check("bp_no_bubble", acc_cyc_q[$], cons_cyc_q[cons_cyc_q.size() - 2]);
    check("bp_second_res", last_res, 8'h53);

    // Back-to-back stream of all eight ops.
    base       = acc_cyc_q.size();
    base_count = exp_count;
    for (int i = 0; i < 8; i++) begin
      c.op = 3'(i);
      c.a  = 8'($urandom);
      c.b  = 8'($urandom);
      cmd_q.push_back(c);
    end
    wait_idle(100);
    for (int k = 1; k < 8; k++)
      check("stream_spacing", acc_cyc_q[base + k] - acc_cyc_q[base + k - 1], 2);
    check("stream_span", cons_cyc_q[$] - acc_cyc_q[base], 16);
    check("stream_count", ifc.op_count, (base_count + 8) % (1 << CNT_W));
    check("stream_last_sel", ifc.sel, OP_7);

    // Reset one cycle after accept: command is dropped.
    base = acc_cyc_q.size();
    cmd_q.push_back('{op: OP_2, a: 8'hF0, b: 8'h3C});
    n = 0;
    while (acc_cyc_q.size() == base && n < 20) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("abort_accepted", acc_cyc_q.size(), base + 1);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    sb_q.delete();
    acc_pending = 0;
    exp_sel     = '0;
    exp_fa      = '0;
    exp_fb      = '0;
    exp_count   = 0;
    #1;
    check_reset_values("abort");
    repeat (2) begin
      @(negedge clk);
      #3;
      check("abort_hold_valid", ifc.out_valid, 0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    cmd_q.push_back('{op: OP_5, a: 8'h0F, b: 8'h00});
    wait_idle(50);
    check("post_abort_res", last_res, 8'hF0);
    check("post_abort_count", ifc.op_count, 1);

    // Random traffic with random backpressure and input gaps.
    ready_mode = 1;
    gap_pct    = 30;
    for (int i = 0; i < 200; i++) begin
      c.op = 3'($urandom_range(0, 7));
      c.a  = 8'($urandom);
      c.b  = 8'($urandom);
      cmd_q.push_back(c);
    end
    wait_idle(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit in case a phase never returns.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
